// File: rtl/dmem_arbiter.sv
// Two-port (core / DMA) arbiter in front of a single-port data memory.
// Core has priority; a starvation counter briefly hands priority to DMA.
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        core_req_valid,
   output logic        core_req_ready,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [3:0]  core_be,
   output logic        core_rsp_valid,
   output logic [31:0] core_rdata,

   input  logic        dma_req_valid,
   output logic        dma_req_ready,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic [3:0]  dma_be,
   output logic        dma_rsp_valid,
   output logic [31:0] dma_rdata,

   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {PRIO_CORE, PRIO_DMA} prio_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DMA} owner_t;

   prio_t      state, state_next;
   owner_t     rsp_owner;
   logic       rsp_read;
   logic [3:0] starve_cnt, starve_next;

   // Grant is purely combinational; gated by rst_n so nothing is granted in reset.
   always_comb begin
      core_req_ready = 1'b0;
      dma_req_ready  = 1'b0;
      if (rst_n) begin
         if (state == PRIO_DMA) begin
            if (dma_req_valid)       dma_req_ready  = 1'b1;
            else if (core_req_valid) core_req_ready = 1'b1;
         end else begin
            if (core_req_valid)      core_req_ready = 1'b1;
            else if (dma_req_valid)  dma_req_ready  = 1'b1;
         end
      end
   end

   always_comb begin
      mem_en    = core_req_ready | dma_req_ready;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (core_req_ready) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
         mem_be    = core_be;
      end else if (dma_req_ready) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_be    = dma_be;
      end
   end

   // State flips in the same edge the counter saturates, so DMA wins the very next cycle.
   always_comb begin
      starve_next = starve_cnt;
      if (!dma_req_valid || dma_req_ready)
         starve_next = '0;
      else if (starve_cnt < LIMIT)
         starve_next = starve_cnt + 4'd1;

      state_next = state;
      case (state)
         PRIO_CORE: if (starve_next == LIMIT) state_next = PRIO_DMA;
         PRIO_DMA:  if (dma_req_ready || !dma_req_valid) state_next = PRIO_CORE;
         default:   state_next = PRIO_CORE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= PRIO_CORE;
         starve_cnt <= '0;
         rsp_owner  <= OWN_NONE;
         rsp_read   <= 1'b0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         rsp_read   <= mem_en & ~mem_we;
         if (core_req_ready)     rsp_owner <= OWN_CORE;
         else if (dma_req_ready) rsp_owner <= OWN_DMA;
         else                    rsp_owner <= OWN_NONE;
      end
   end

   always_comb begin
      core_rsp_valid = (rsp_owner == OWN_CORE);
      dma_rsp_valid  = (rsp_owner == OWN_DMA);
      core_rdata     = (core_rsp_valid && rsp_read) ? mem_rdata : '0;
      dma_rdata      = (dma_rsp_valid  && rsp_read) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small registered-read memory model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req_valid, core_req_ready, core_we, core_rsp_valid;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic [3:0]  core_be;
   logic        dma_req_valid, dma_req_ready, dma_we, dma_rsp_valid;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic [3:0]  dma_be;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   logic [31:0] mem [256];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic        prev_dma;
   logic        exp_dma;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
      .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata), .core_be(core_be),
      .core_rsp_valid(core_rsp_valid), .core_rdata(core_rdata),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
      .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_be(dma_be),
      .dma_rsp_valid(dma_rsp_valid), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem[mem_addr[9:2]];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_core(input logic v, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
      core_req_valid = v; core_we = we; core_addr = a; core_wdata = d; core_be = be;
   endtask

   task automatic drive_dma(input logic v, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be);
      dma_req_valid = v; dma_we = we; dma_addr = a; dma_wdata = d; dma_be = be;
   endtask

   task automatic idle;
      drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      drive_core(1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 4'hF);
      #3;
      chk("rst_core_ready", 32'(core_req_ready), 32'h0);
      chk("rst_mem_en",     32'(mem_en),         32'h0);
      chk("rst_mem_we",     32'(mem_we),         32'h0);
      chk("rst_core_rsp",   32'(core_rsp_valid), 32'h0);
      chk("rst_core_rdata", core_rdata,          32'h0);
      chk("rst_dma_rdata",  dma_rdata,           32'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      idle();

      // core store then load
      @(negedge clk); drive_core(1'b1, 1'b1, 32'h80, 32'hFEEDF00D, 4'hF); #1;
      chk("sw_core_ready", 32'(core_req_ready), 32'h1);
      chk("sw_mem_we",     32'(mem_we),         32'h1);
      chk("sw_mem_be",     32'(mem_be),         32'hF);
      chk("sw_mem_addr",   mem_addr,            32'h80);
      chk("sw_mem_wdata",  mem_wdata,           32'hFEEDF00D);
      @(negedge clk); drive_core(1'b1, 1'b0, 32'h80, 32'h0, 4'hF); #1;
      chk("sw_ack",        32'(core_rsp_valid), 32'h1);
      chk("sw_ack_rdata",  core_rdata,          32'h0);
      chk("lw_mem_we",     32'(mem_we),         32'h0);
      chk("lw_core_ready", 32'(core_req_ready), 32'h1);
      @(negedge clk); idle(); #1;
      chk("lw_rsp",        32'(core_rsp_valid), 32'h1);
      chk("lw_rdata",      core_rdata,          32'hFEEDF00D);
      chk("lw_dma_rsp",    32'(dma_rsp_valid),  32'h0);
      chk("idle_mem_en",   32'(mem_en),         32'h0);
      @(negedge clk); #1;
      chk("idle_core_rsp", 32'(core_rsp_valid), 32'h0);

      // DMA alone: store then load at 0x100
      @(negedge clk); drive_dma(1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF); #1;
      chk("dsw_ready",     32'(dma_req_ready),  32'h1);
      chk("dsw_mem_addr",  mem_addr,            32'h100);
      @(negedge clk); drive_dma(1'b1, 1'b0, 32'h100, 32'h0, 4'hF); #1;
      chk("dlw_ready",     32'(dma_req_ready),  32'h1);
      chk("dlw_core_rdy",  32'(core_req_ready), 32'h0);
      chk("dsw_ack",       32'(dma_rsp_valid),  32'h1);
      @(negedge clk); idle(); #1;
      chk("dlw_rsp",       32'(dma_rsp_valid),  32'h1);
      chk("dlw_rdata",     dma_rdata,           32'h12345678);
      chk("dlw_core_rsp",  32'(core_rsp_valid), 32'h0);
      chk("dlw_core_rdata", core_rdata,         32'h0);

      // continuous contention: core x4, DMA x1, repeat
      prev_dma = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         drive_core(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
         drive_dma(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
         #1;
         exp_dma = (i % 5 == 0);
         chk($sformatf("cont%0d_core_rdy", i), 32'(core_req_ready), 32'(!exp_dma));
         chk($sformatf("cont%0d_dma_rdy", i),  32'(dma_req_ready),  32'(exp_dma));
         if (i > 1) begin
            chk($sformatf("cont%0d_core_rsp", i), 32'(core_rsp_valid), 32'(!prev_dma));
            chk($sformatf("cont%0d_dma_rsp", i),  32'(dma_rsp_valid),  32'(prev_dma));
            chk($sformatf("cont%0d_core_rd", i), core_rdata, prev_dma ? 32'h0 : 32'hFEEDF00D);
            chk($sformatf("cont%0d_dma_rd", i),  dma_rdata,  prev_dma ? 32'h12345678 : 32'h0);
         end else begin
            chk("cont1_no_rsp", 32'(core_rsp_valid | dma_rsp_valid), 32'h0);
         end
         prev_dma = exp_dma;
      end
      @(negedge clk); idle(); #1;
      chk("cont_last_rsp", 32'(core_rsp_valid), 32'h1);

      // DMA drops after 3 blocked cycles: counter clears, priority stays with core
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_core(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
         drive_dma(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
         #1;
         chk($sformatf("drop%0d_core_rdy", i), 32'(core_req_ready), 32'h1);
      end
      chk("drop_cnt_before", 32'(dut.starve_cnt), 32'h2);
      @(negedge clk); drive_dma(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
      @(negedge clk); #1;
      chk("drop_cnt_clear", 32'(dut.starve_cnt), 32'h0);
      chk("drop_state",     32'(dut.state),      32'h0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         drive_dma(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
         #1;
         chk($sformatf("restart%0d_dma_rdy", i), 32'(dma_req_ready), 32'(i == 5));
      end

      // alternate single requesters every cycle
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive_core((i % 2) == 0, 1'b0, 32'h80, 32'h0, 4'hF);
         drive_dma((i % 2) == 1, 1'b0, 32'h100, 32'h0, 4'hF);
         #1;
         chk($sformatf("alt%0d_core_rdy", i), 32'(core_req_ready), 32'((i % 2) == 0));
         if (i > 0) begin
            chk($sformatf("alt%0d_core_rd", i), core_rdata, ((i % 2) == 1) ? 32'hFEEDF00D : 32'h0);
            chk($sformatf("alt%0d_dma_rd", i),  dma_rdata,  ((i % 2) == 0) ? 32'h12345678 : 32'h0);
            chk($sformatf("alt%0d_dma_rsp", i), 32'(dma_rsp_valid), 32'((i % 2) == 0));
         end
      end
      @(negedge clk); idle(); #1;
      chk("alt_last_rsp", 32'(dma_rsp_valid), 32'h1);

      // reset right after a core read grant drops the response
      @(negedge clk); drive_core(1'b1, 1'b0, 32'h80, 32'h0, 4'hF); #1;
      chk("prerst_core_rdy", 32'(core_req_ready), 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive_dma(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      #1;
      chk("midrst_core_rsp", 32'(core_rsp_valid), 32'h0);
      @(negedge clk); #1;
      chk("inrst_core_rdy",  32'(core_req_ready), 32'h0);
      chk("inrst_dma_rdy",   32'(dma_req_ready),  32'h0);
      chk("inrst_mem_en",    32'(mem_en),         32'h0);
      chk("inrst_mem_be",    32'(mem_be),         32'h0);
      chk("inrst_core_rd",   core_rdata,          32'h0);
      @(negedge clk); rst_n = 1'b1; idle(); #1;
      chk("postrst_core_rsp", 32'(core_rsp_valid), 32'h0);
      chk("postrst_cnt",      32'(dut.starve_cnt), 32'h0);
      @(negedge clk);
      drive_core(1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
      drive_dma(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      #1;
      chk("postrst_core_grant", 32'(core_req_ready), 32'h1);
      chk("postrst_dma_grant",  32'(dma_req_ready),  32'h0);
      @(negedge clk); idle(); #1;
      chk("postrst_rsp", 32'(core_rsp_valid), 32'h1);
      chk("postrst_rd",  core_rdata,          32'hFEEDF00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
